// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect controls, instruction-memory port and the F/D payload.
// The master side belongs to fetch_stage; the slave side faces memory, hazard unit, execute and decode.
interface fetch_stage_if #(
    parameter int W    = 16,
    parameter int PC_W = 20
);
    logic              stall;
    logic              branch_taken;
    logic [PC_W-1:0]   branch_target;
    logic [PC_W-1:0]   imem_addr;
    logic [W-1:0]      imem_data;
    logic [2*W-1:0]    fd_data;
    logic              fd_valid;
    logic [PC_W-1:0]   fd_pc;

    modport master (
        input  stall, branch_taken, branch_target, imem_data,
        output imem_addr, fd_data, fd_valid, fd_pc
    );

    modport slave (
        output stall, branch_taken, branch_target, imem_data,
        input  imem_addr, fd_data, fd_valid, fd_pc
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: boots the PC from instruction memory, assembles one/two-word
// instructions into the registered F/D payload, and honours stalls and branch redirects.
module fetch_stage #(
    parameter int              W         = 16,
    parameter int              PC_W      = 20,
    parameter logic [PC_W-1:0] RESET_VEC = '0
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);
    typedef enum logic [1:0] {BOOT, FETCH, IMM} state_t;

    state_t            state, state_n;
    logic [PC_W-1:0]   pc, pc_n;
    logic [W-1:0]      hold_ir, hold_ir_n;
    logic [PC_W-1:0]   hold_pc, hold_pc_n;
    logic [2*W-1:0]    fd_data_n;
    logic              fd_valid_n;
    logic [PC_W-1:0]   fd_pc_n;

    // Zero-extends or truncates the boot word, whichever way the widths differ.
    function automatic logic [PC_W-1:0] boot_pc(input logic [W-1:0] word);
        logic [PC_W+W-1:0] ext;
        ext = {{PC_W{1'b0}}, word};
        return ext[PC_W-1:0];
    endfunction

    assign bus.imem_addr = (state == BOOT) ? RESET_VEC : pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= BOOT;
        else     state <= state_n;
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        hold_ir_n  = hold_ir;
        hold_pc_n  = hold_pc;
        fd_data_n  = bus.fd_data;
        fd_valid_n = bus.fd_valid;
        fd_pc_n    = bus.fd_pc;

        unique case (state)
            BOOT: begin
                pc_n       = boot_pc(bus.imem_data);
                fd_valid_n = 1'b0;
                fd_data_n  = '0;
                state_n    = FETCH;
            end
            FETCH: begin
                if (bus.branch_taken) begin
                    pc_n       = bus.branch_target;
                    fd_valid_n = 1'b0;
                    fd_data_n  = '0;
                end else if (!bus.stall) begin
                    pc_n = pc + PC_W'(1);
                    if (bus.imem_data[W-1]) begin
                        // First word of a two-word instruction: park it, emit a bubble.
                        hold_ir_n  = bus.imem_data;
                        hold_pc_n  = pc;
                        fd_valid_n = 1'b0;
                        fd_data_n  = '0;
                        state_n    = IMM;
                    end else begin
                        fd_data_n  = {bus.imem_data, {W{1'b0}}};
                        fd_pc_n    = pc;
                        fd_valid_n = 1'b1;
                    end
                end
            end
            IMM: begin
                if (bus.branch_taken) begin
                    pc_n       = bus.branch_target;
                    hold_ir_n  = '0;
                    fd_valid_n = 1'b0;
                    fd_data_n  = '0;
                    state_n    = FETCH;
                end else if (!bus.stall) begin
                    fd_data_n  = {hold_ir, bus.imem_data};
                    fd_pc_n    = hold_pc;
                    fd_valid_n = 1'b1;
                    pc_n       = pc + PC_W'(1);
                    state_n    = FETCH;
                end
            end
            default: state_n = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc           <= '0;
            hold_ir      <= '0;
            hold_pc      <= '0;
            bus.fd_data  <= '0;
            bus.fd_valid <= 1'b0;
            bus.fd_pc    <= '0;
        end else begin
            pc           <= pc_n;
            hold_ir      <= hold_ir_n;
            hold_pc      <= hold_pc_n;
            bus.fd_data  <= fd_data_n;
            bus.fd_valid <= fd_valid_n;
            bus.fd_pc    <= fd_pc_n;
        end
    end
endmodule
